// File: rtl/axil_rd_arb.sv
// Round-robin arbiter sharing one AXI4-lite read path (AR + R) among
// S_COUNT upstream requesters. One read is in flight at a time, and the
// grant is held from AR acceptance until the matching R handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no read in flight; pick the next requester (arbitration bubble)
// ADDR  | present the granted requester's AR to the downstream slave
// RESP  | route the downstream R beat back to the granted requester
module axil_rd_arb #(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [S_COUNT*3-1:0]          s_axil_arprot,
  input  logic [S_COUNT-1:0]            s_axil_arvalid,
  output logic [S_COUNT-1:0]            s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
  output logic [S_COUNT*2-1:0]          s_axil_rresp,
  output logic [S_COUNT-1:0]            s_axil_rvalid,
  input  logic [S_COUNT-1:0]            s_axil_rready,
  output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
  output logic [2:0]                    m_axil_arprot,
  output logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  output logic                          m_axil_rready,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] last_idx;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_found;
  logic                 sel_rready;
  int unsigned          cand;
  logic [S_COUNT-1:0]   rot;

  // Round-robin search: first arvalid found walking upward from last+1 with wrap.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    rot       = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      cand = (int'(last_idx) + k) % S_COUNT;
      rot  = s_axil_arvalid >> cand;
      if (!win_found && rot[0]) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  // Steer AR from the granted slot down, and R handshake signals back to it.
  always_comb begin
    m_axil_araddr  = '0;
    m_axil_arprot  = '0;
    sel_rready     = 1'b0;
    s_axil_arready = '0;
    s_axil_rvalid  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_idx == IDX_WIDTH'(i)) begin
        m_axil_araddr = s_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_axil_arprot = s_axil_arprot[i*3 +: 3];
        sel_rready    = s_axil_rready[i];
        if (state == ADDR) s_axil_arready[i] = m_axil_arready;
        if (state == RESP) s_axil_rvalid[i]  = m_axil_rvalid;
      end
    end
  end

  // Handshake qualifiers come from the state register so reset clears them at once.
  always_comb begin
    m_axil_arvalid = (state == ADDR);
    m_axil_rready  = (state == RESP) && sel_rready;
    busy           = (state != IDLE);
    s_axil_rdata   = {S_COUNT{m_axil_rdata}};
    s_axil_rresp   = {S_COUNT{m_axil_rresp}};
  end

  // Sequencer: arbitrate, issue AR, wait for R; pointer advances only on R completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      last_idx  <= IDX_WIDTH'(S_COUNT - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_axil_arready) state <= RESP;
        end
        RESP: begin
          if (m_axil_rvalid && sel_rready) begin
            last_idx <= grant_idx;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_rd_arb.sv
// Directed bench for axil_rd_arb: a 2-requester instance exercises single
// reads, backpressure, spurious R, async reset mid-response and contention;
// a 4-requester instance with an always-ready slave checks rotation fairness.
module tb_axil_rd_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst_n;

  logic [2*AW-1:0] a_s_araddr;
  logic [5:0]      a_s_arprot;
  logic [1:0]      a_s_arvalid;
  logic [1:0]      a_s_arready;
  logic [2*DW-1:0] a_s_rdata;
  logic [3:0]      a_s_rresp;
  logic [1:0]      a_s_rvalid;
  logic [1:0]      a_s_rready;
  logic [AW-1:0]   a_m_araddr;
  logic [2:0]      a_m_arprot;
  logic            a_m_arvalid;
  logic            a_m_arready;
  logic [DW-1:0]   a_m_rdata;
  logic [1:0]      a_m_rresp;
  logic            a_m_rvalid;
  logic            a_m_rready;
  logic [0:0]      a_grant;
  logic            a_busy;

  logic [4*AW-1:0] b_s_araddr;
  logic [11:0]     b_s_arprot;
  logic [3:0]      b_s_arvalid;
  logic [3:0]      b_s_arready;
  logic [4*DW-1:0] b_s_rdata;
  logic [7:0]      b_s_rresp;
  logic [3:0]      b_s_rvalid;
  logic [3:0]      b_s_rready;
  logic [AW-1:0]   b_m_araddr;
  logic [2:0]      b_m_arprot;
  logic            b_m_arvalid;
  logic            b_m_arready;
  logic [DW-1:0]   b_m_rdata;
  logic [1:0]      b_m_rresp;
  logic            b_m_rvalid;
  logic            b_m_rready;
  logic [1:0]      b_grant;
  logic            b_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int hs_before;

  axil_rd_arb #(.S_COUNT(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(a_s_araddr), .s_axil_arprot(a_s_arprot),
    .s_axil_arvalid(a_s_arvalid), .s_axil_arready(a_s_arready),
    .s_axil_rdata(a_s_rdata), .s_axil_rresp(a_s_rresp),
    .s_axil_rvalid(a_s_rvalid), .s_axil_rready(a_s_rready),
    .m_axil_araddr(a_m_araddr), .m_axil_arprot(a_m_arprot),
    .m_axil_arvalid(a_m_arvalid), .m_axil_arready(a_m_arready),
    .m_axil_rdata(a_m_rdata), .m_axil_rresp(a_m_rresp),
    .m_axil_rvalid(a_m_rvalid), .m_axil_rready(a_m_rready),
    .grant_idx(a_grant), .busy(a_busy)
  );

  axil_rd_arb #(.S_COUNT(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axil_araddr(b_s_araddr), .s_axil_arprot(b_s_arprot),
    .s_axil_arvalid(b_s_arvalid), .s_axil_arready(b_s_arready),
    .s_axil_rdata(b_s_rdata), .s_axil_rresp(b_s_rresp),
    .s_axil_rvalid(b_s_rvalid), .s_axil_rready(b_s_rready),
    .m_axil_araddr(b_m_araddr), .m_axil_arprot(b_m_arprot),
    .m_axil_arvalid(b_m_arvalid), .m_axil_arready(b_m_arready),
    .m_axil_rdata(b_m_rdata), .m_axil_rresp(b_m_rresp),
    .m_axil_rvalid(b_m_rvalid), .m_axil_rready(b_m_rready),
    .grant_idx(b_grant), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed downstream R handshakes on instance A.
  always @(posedge clk) begin
    if (rst_n && a_m_rvalid && a_m_rready) hs_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a_addr();
    int n = 0;
    while (a_m_arvalid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("a_ar_timeout", a_m_arvalid, 1);
  endtask

  task automatic a_read(input int g, input logic [31:0] addr, input logic [31:0] data);
    wait_a_addr();
    chk("a_grant", a_grant, g);
    chk("a_araddr", a_m_araddr, addr);
    a_m_arready = 1'b1;
    #1;
    chk("a_s_arready", a_s_arready, 64'(1 << g));
    tick();
    a_m_arready = 1'b0;
    a_m_rvalid  = 1'b1;
    a_m_rdata   = data;
    a_s_rready  = 2'b11;
    #1;
    chk("a_s_rvalid", a_s_rvalid, 64'(1 << g));
    chk("a_s_rdata", a_s_rdata[g*DW +: DW], data);
    tick();
    a_m_rvalid = 1'b0;
    a_s_rready = 2'b00;
  endtask

  task automatic b_next_grant(input int g);
    int n = 0;
    while (b_m_arvalid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("b_ar_timeout", b_m_arvalid, 1);
    chk("b_grant", b_grant, g);
    chk("b_araddr", b_m_araddr, 64'(32'h1000 * (g + 1)));
    tick();
  endtask

  initial begin
    a_s_araddr  = '0;
    a_s_arprot  = '0;
    a_s_arvalid = '0;
    a_s_rready  = '0;
    a_m_arready = 1'b0;
    a_m_rdata   = '0;
    a_m_rresp   = 2'b00;
    a_m_rvalid  = 1'b0;
    b_s_araddr  = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    b_s_arprot  = '0;
    b_s_arvalid = '0;
    b_s_rready  = 4'hF;
    b_m_arready = 1'b1;
    b_m_rdata   = 32'h5A5A5A5A;
    b_m_rresp   = 2'b00;
    b_m_rvalid  = 1'b1;
    rst_n       = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_busy", a_busy, 0);
    chk("rst_m_arvalid", a_m_arvalid, 0);
    chk("rst_m_rready", a_m_rready, 0);
    chk("rst_s_arready", a_s_arready, 0);
    chk("rst_s_rvalid", a_s_rvalid, 0);
    chk("rst_grant", a_grant, 0);

    // single read from s0
    rst_n = 1'b1;
    a_s_arvalid = 2'b01;
    a_s_araddr[31:0] = 32'h100;
    a_s_arprot[2:0] = 3'b010;
    #1;
    chk("c1_m_arvalid", a_m_arvalid, 0);
    chk("c1_s_arready", a_s_arready, 0);
    tick();
    chk("c2_m_arvalid", a_m_arvalid, 1);
    chk("c2_araddr", a_m_araddr, 32'h100);
    chk("c2_arprot", a_m_arprot, 3'b010);
    chk("c2_busy", a_busy, 1);
    chk("c2_grant", a_grant, 0);
    chk("c2_s_arready_wait", a_s_arready, 0);
    a_m_arready = 1'b1;
    #1;
    chk("c2_s_arready", a_s_arready, 2'b01);
    tick();
    a_m_arready = 1'b0;
    a_s_arvalid = 2'b00;
    chk("c3_m_arvalid", a_m_arvalid, 0);
    chk("c3_busy", a_busy, 1);
    a_m_rvalid = 1'b1;
    a_m_rdata  = 32'hDEADBEEF;
    a_s_rready = 2'b01;
    #1;
    chk("c3_s_rvalid", a_s_rvalid, 2'b01);
    chk("c3_s0_rdata", a_s_rdata[31:0], 32'hDEADBEEF);
    chk("c3_m_rready", a_m_rready, 1);
    tick();
    a_m_rvalid = 1'b0;
    a_s_rready = 2'b00;
    chk("c4_busy", a_busy, 0);
    chk("c4_s_rvalid", a_s_rvalid, 0);

    // backpressure on AR then on R
    a_s_arvalid = 2'b01;
    a_s_araddr[31:0] = 32'h400;
    wait_a_addr();
    for (int i = 0; i < 5; i++) begin
      chk("bp_araddr", a_m_araddr, 32'h400);
      chk("bp_s_arready", a_s_arready, 0);
      tick();
    end
    a_m_arready = 1'b1;
    #1;
    chk("bp_s_arready_go", a_s_arready, 2'b01);
    hs_before = hs_cnt;
    tick();
    a_m_arready = 1'b0;
    a_s_arvalid = 2'b00;
    a_m_rvalid  = 1'b1;
    a_m_rdata   = 32'h12345678;
    a_s_rready  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_m_rready_low", a_m_rready, 0);
      chk("bp_s_rvalid", a_s_rvalid, 2'b01);
      chk("bp_busy", a_busy, 1);
      tick();
    end
    a_s_rready = 2'b01;
    #1;
    chk("bp_m_rready_high", a_m_rready, 1);
    tick();
    a_m_rvalid = 1'b0;
    a_s_rready = 2'b00;
    chk("bp_idle", a_busy, 0);
    chk("bp_one_handshake", hs_cnt - hs_before, 1);

    // spurious downstream rvalid while idle
    a_m_rvalid = 1'b1;
    #1;
    chk("sp_m_rready", a_m_rready, 0);
    chk("sp_s_rvalid", a_s_rvalid, 0);
    tick();
    tick();
    chk("sp_busy", a_busy, 0);
    chk("sp_m_arvalid", a_m_arvalid, 0);
    chk("sp_s_rvalid2", a_s_rvalid, 0);
    a_m_rvalid = 1'b0;

    // async reset while in RESP
    a_s_arvalid = 2'b10;
    a_s_araddr[63:32] = 32'h500;
    wait_a_addr();
    chk("ar_grant", a_grant, 1);
    chk("ar_araddr", a_m_araddr, 32'h500);
    a_m_arready = 1'b1;
    tick();
    a_m_arready = 1'b0;
    a_s_arvalid = 2'b00;
    a_m_rvalid  = 1'b1;
    a_s_rready  = 2'b00;
    #1;
    chk("ar_s_rvalid", a_s_rvalid, 2'b10);
    chk("ar_busy", a_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rst_busy", a_busy, 0);
    chk("ar_rst_m_rready", a_m_rready, 0);
    chk("ar_rst_s_rvalid", a_s_rvalid, 0);
    chk("ar_rst_grant", a_grant, 0);
    a_m_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // contention after reset: pointer restarts at s0
    a_s_araddr  = {32'h700, 32'h600};
    a_s_arvalid = 2'b11;
    a_read(0, 32'h600, 32'hA0000000);
    a_read(1, 32'h700, 32'hA0000001);
    a_read(0, 32'h600, 32'hA0000002);
    a_read(1, 32'h700, 32'hA0000003);
    a_s_arvalid = 2'b00;

    // four requesters: full rotation, then s3 against s0
    b_s_arvalid = 4'b1111;
    for (int r = 0; r < 8; r++) b_next_grant(r % 4);
    b_s_arvalid = 4'b1001;
    b_next_grant(0);
    b_next_grant(3);
    b_next_grant(0);
    b_next_grant(3);
    b_s_arvalid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
